huitailang_move_ctrl: RTL
=========================

HUITAILANG_MOVE_CTRL -- requirements
Module: huitailang_move_ctrl

Interface
REQ-001 Parameter X_STEP, default 2, horizontal pixels moved per frame.
REQ-002 Parameter FALL_STEP, default 4, downward pixels per frame while falling.
REQ-003 Parameter RISE_STEP, default 1, upward pixels per frame while standing on a rising floor.
REQ-004 Parameter RX_LIM, default 370, symmetric saturation limit for rel_xx (range -RX_LIM..+RX_LIM).
REQ-005 Parameter Y_TOP, default 0, and Y_BOTTOM, default 550, vertical death limits for cnt_life.
REQ-006 Parameter Y_START, default 100, cnt_life load value.
REQ-007 clk_50m  input  1  sole clock, all state on rising edge.
REQ-008 rst  input  1  reset; asynchronous, active-high.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame, issued during vertical blank.
REQ-010 game_start  input  1  one-cycle start/restart pulse.
REQ-011 key_left, key_right  input  1 each  debounced level buttons.
REQ-012 on_floor  input  1  level, 1 when the sprite bottom rests on a floor; sampled only on frame_tick.
REQ-013 rel_xx  output  12 signed  horizontal offset; sprite left edge = 375 - rel_xx.
REQ-014 cnt_life  output  10  sprite top row.
REQ-015 face_RL  output  1  0 = facing left, 1 = facing right.
REQ-016 up_flg  output  1  1 = reversed-sprite readout (falling image).
REQ-017 dead  output  1  1 while in DEAD.
REQ-018 state  output  2  IDLE=0, STAND=1, FALL=2, DEAD=3.

Function
REQ-019 The controller SHALL be a four-state FSM: IDLE, STAND, FALL, DEAD; all outputs registered.
REQ-020 Position, facing and state updates SHALL occur only on cycles with frame_tick=1, except game_start handling (REQ-021).
REQ-021 In IDLE or DEAD, game_start SHALL, on the next edge, load rel_xx=0, cnt_life=Y_START, face_RL=0, and enter FALL, regardless of frame_tick.
REQ-022 game_start SHALL be ignored in STAND and FALL.
REQ-023 STAND on frame_tick: on_floor=0 -> FALL, cnt_life unchanged; on_floor=1 -> cnt_life -= RISE_STEP.
REQ-024 STAND: if the new cnt_life would be <= Y_TOP, cnt_life SHALL saturate at Y_TOP and the state SHALL become DEAD in the same update.
REQ-025 FALL on frame_tick: on_floor=1 -> STAND, cnt_life unchanged; on_floor=0 -> cnt_life += FALL_STEP.
REQ-026 FALL: if the new cnt_life would be >= Y_BOTTOM, cnt_life SHALL saturate at Y_BOTTOM and the state SHALL become DEAD in the same update.
REQ-027 Horizontal, in STAND/FALL on frame_tick: key_left only -> rel_xx += X_STEP, face_RL=0; key_right only -> rel_xx -= X_STEP, face_RL=1; both or neither -> rel_xx and face_RL hold.
REQ-028 rel_xx SHALL saturate at +RX_LIM/-RX_LIM; arithmetic SHALL use at least 13 bits signed so no wrap occurs.
REQ-029 Vertical arithmetic SHALL use at least 11 bits unsigned so no wrap occurs below 0 or above 1023.
REQ-030 Horizontal and vertical updates SHALL apply together on the same frame_tick, including the tick that enters DEAD.
REQ-031 up_flg SHALL be 1 exactly while state=FALL; 0 otherwise.
REQ-032 dead SHALL be 1 exactly while state=DEAD.
REQ-033 In IDLE and DEAD, rel_xx, cnt_life and face_RL SHALL hold, and keys/on_floor/frame_tick SHALL be ignored.
REQ-034 Latency: outputs SHALL reflect a frame_tick or game_start update on the clock edge that samples it (one cycle).

Reset
REQ-035 rst=1 SHALL asynchronously force state=IDLE, rel_xx=0, cnt_life=Y_START, face_RL=0, up_flg=0, dead=0.
REQ-036 Assertion of rst mid-frame or mid-move SHALL abandon the pending update; after release, the FSM SHALL stay in IDLE until game_start.

Verification
REQ-037 Reset, then game_start -> next cycle state=FALL, up_flg=1, cnt_life=100; three frame_ticks with on_floor=0 -> cnt_life=112.
REQ-038 In FALL, on_floor=1 at a frame_tick -> state=STAND, up_flg=0, cnt_life unchanged; next tick with on_floor=1 -> cnt_life decreases by 1.
REQ-039 key_right held for 200 ticks from rel_xx=0 -> rel_xx=-370 saturated, face_RL=1; both keys then pressed -> rel_xx and face_RL hold.
REQ-040 FALL with cnt_life=548, on_floor=0, tick -> cnt_life=550, state=DEAD, dead=1; game_start -> FALL, cnt_life=100, rel_xx=0.
REQ-041 STAND with cnt_life=1 and a tick -> cnt_life=0, state=DEAD; further ticks and key presses -> no output change.
REQ-042 rst asserted between edges while in STAND -> outputs at reset values immediately, before the next clk_50m edge.

Source files
------------

// File: rtl/huitailang_move_ctrl.sv
// Sprite movement controller: four-state FSM (IDLE/STAND/FALL/DEAD) that moves the
// sprite horizontally by key and vertically by floor contact, once per video frame.
module huitailang_move_ctrl #(
  parameter int X_STEP    = 2,
  parameter int FALL_STEP = 4,
  parameter int RISE_STEP = 1,
  parameter int RX_LIM    = 370,
  parameter int Y_TOP     = 0,
  parameter int Y_BOTTOM  = 550,
  parameter int Y_START   = 100
) (
  input  logic               clk_50m,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               game_start,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               on_floor,
  output logic signed [11:0] rel_xx,
  output logic        [9:0]  cnt_life,
  output logic               face_RL,
  output logic               up_flg,
  output logic               dead,
  output logic        [1:0]  state
);

  localparam int unsigned RX_W  = 12;
  localparam int unsigned RXE_W = 13;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned VE_W  = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STAND = 2'd1;
  localparam logic [1:0] S_FALL  = 2'd2;
  localparam logic [1:0] S_DEAD  = 2'd3;

  localparam logic signed [RXE_W-1:0] C_X_STEP = RXE_W'(X_STEP);
  localparam logic signed [RXE_W-1:0] C_RX_POS = RXE_W'(RX_LIM);
  localparam logic signed [RXE_W-1:0] C_RX_NEG = RXE_W'(-RX_LIM);
  localparam logic signed [VE_W-1:0]  C_FALL   = VE_W'(FALL_STEP);
  localparam logic signed [VE_W-1:0]  C_RISE   = VE_W'(RISE_STEP);
  localparam logic signed [VE_W-1:0]  C_Y_TOP  = VE_W'(Y_TOP);
  localparam logic signed [VE_W-1:0]  C_Y_BOT  = VE_W'(Y_BOTTOM);
  localparam logic [CNT_W-1:0]        C_Y_START = CNT_W'(Y_START);

  logic [1:0]              r_state;
  logic signed [RX_W-1:0]  r_rel_xx;
  logic [CNT_W-1:0]        r_cnt_life;
  logic                    r_face_rl;
  logic                    r_up_flg;
  logic                    r_dead;

  logic [1:0]              w_state_nxt;
  logic signed [RX_W-1:0]  w_rel_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_face_nxt;

  logic signed [VE_W-1:0]  w_v_up;
  logic signed [VE_W-1:0]  w_v_dn;
  logic signed [RXE_W-1:0] w_rx_inc;
  logic signed [RXE_W-1:0] w_rx_dec;
  logic                    w_left_only;
  logic                    w_right_only;
  logic                    w_active_tick;
  logic                    w_hit_top;
  logic                    w_hit_bot;

  // Widened arithmetic so neither axis can wrap before saturation is applied.
  assign w_v_up        = $signed({2'b00, r_cnt_life}) - C_RISE;
  assign w_v_dn        = $signed({2'b00, r_cnt_life}) + C_FALL;
  assign w_rx_inc      = $signed({r_rel_xx[RX_W-1], r_rel_xx}) + C_X_STEP;
  assign w_rx_dec      = $signed({r_rel_xx[RX_W-1], r_rel_xx}) - C_X_STEP;
  assign w_left_only   = key_left & ~key_right;
  assign w_right_only  = key_right & ~key_left;
  assign w_active_tick = frame_tick & ((r_state == S_STAND) | (r_state == S_FALL));
  assign w_hit_top     = (w_v_up <= C_Y_TOP);
  assign w_hit_bot     = (w_v_dn >= C_Y_BOT);

  // State and output registers.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rel_xx   <= '0;
      r_cnt_life <= C_Y_START;
      r_face_rl  <= 1'b0;
      r_up_flg   <= 1'b0;
      r_dead     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rel_xx   <= w_rel_nxt;
      r_cnt_life <= w_cnt_nxt;
      r_face_rl  <= w_face_nxt;
      r_up_flg   <= (w_state_nxt == S_FALL);
      r_dead     <= (w_state_nxt == S_DEAD);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DEAD: begin
        if (game_start) w_state_nxt = S_FALL;
      end
      S_STAND: begin
        if (frame_tick) begin
          if (!on_floor)      w_state_nxt = S_FALL;
          else if (w_hit_top) w_state_nxt = S_DEAD;
        end
      end
      S_FALL: begin
        if (frame_tick) begin
          if (on_floor)       w_state_nxt = S_STAND;
          else if (w_hit_bot) w_state_nxt = S_DEAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: start load, per-frame horizontal and vertical moves.
  always_comb begin
    w_rel_nxt  = r_rel_xx;
    w_cnt_nxt  = r_cnt_life;
    w_face_nxt = r_face_rl;
    if (((r_state == S_IDLE) || (r_state == S_DEAD)) && game_start) begin
      w_rel_nxt  = '0;
      w_cnt_nxt  = C_Y_START;
      w_face_nxt = 1'b0;
    end else if (w_active_tick) begin
      if (w_left_only) begin
        w_rel_nxt  = (w_rx_inc > C_RX_POS) ? RX_W'(C_RX_POS) : RX_W'(w_rx_inc);
        w_face_nxt = 1'b0;
      end else if (w_right_only) begin
        w_rel_nxt  = (w_rx_dec < C_RX_NEG) ? RX_W'(C_RX_NEG) : RX_W'(w_rx_dec);
        w_face_nxt = 1'b1;
      end
      if ((r_state == S_STAND) && on_floor) begin
        w_cnt_nxt = w_hit_top ? CNT_W'(C_Y_TOP) : CNT_W'(w_v_up);
      end else if ((r_state == S_FALL) && !on_floor) begin
        w_cnt_nxt = w_hit_bot ? CNT_W'(C_Y_BOT) : CNT_W'(w_v_dn);
      end
    end
  end

  assign state    = r_state;
  assign rel_xx   = r_rel_xx;
  assign cnt_life = r_cnt_life;
  assign face_RL  = r_face_rl;
  assign up_flg   = r_up_flg;
  assign dead     = r_dead;

endmodule
